usb_reg_master: RTL

USB_REG_MASTER -- requirements
Module: usb_reg_master

---
 rtl/usb_bus_pkg.sv | 24 ++
 rtl/usb_phase_timer.sv | 37 +++
 rtl/usb_reg_master.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/usb_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_bus_pkg
// Description : Shared definitions for the USB register-bus master: the bus
//               sequencer state enum and the default phase timings.
// Revision    : 1.0 - initial release
// ============================================================================
package usb_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5   // zero-length command: one dead cycle before DONE
  } bus_state_t;

  localparam int unsigned C_SETUP_DEF  = 1;
  localparam int unsigned C_STROBE_DEF = 2;
  localparam int unsigned C_HOLD_DEF   = 1;

endpackage : usb_bus_pkg
`default_nettype wire

// File: rtl/usb_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : usb_phase_timer
// Description : Loadable 4-bit down-counter with a zero flag. Loaded with
//               (phase length - 1) on entry to a bus phase; the phase ends in
//               the cycle where o_zero is high. Saturates at zero.
// Ports       : clk_usb    - clock (rising edge)
//               reset      - asynchronous active-high reset
//               i_load     - load i_load_val on the next edge
//               i_load_val - value to load
//               o_zero     - count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module usb_phase_timer (
  input  logic       clk_usb,
  input  logic       reset,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  output logic       o_zero
);

  logic [3:0] r_count;

  always_ff @(posedge clk_usb or posedge reset) begin
    if (reset) begin
      r_count <= 4'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != 4'd0) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign o_zero = (r_count == 4'd0);

endmodule : usb_phase_timer
`default_nettype wire

// File: rtl/usb_reg_master.sv
`default_nettype none
// ============================================================================
// Module      : usb_reg_master
// Description : Command-driven master for an asynchronous 8-bit register bus
//               with active-low chip enable and read/write strobes. Each byte
//               runs SETUP -> STROBE -> HOLD; a command moves 1..127 bytes at
//               consecutive (wrapping) bytecounts of one register address.
// Config      : USB_MASTER_BURST_EN - when defined, multi-byte commands are
//               honoured; otherwise any nonzero cmd_len moves exactly one byte.
// Ports       : clk_usb, reset           - clock / async active-high reset
//               cmd_valid/ready/write/addr/offset/len - command handshake
//               wr_data/wr_valid/wr_ready - write byte stream
//               rd_data/rd_valid          - read byte stream (no backpressure)
//               done/err                  - completion pulse, err qualifies
//               usb_*                     - register bus pins
// Revision    : 1.0 - initial release
// ============================================================================
module usb_reg_master
  import usb_bus_pkg::*;
#(
  parameter int unsigned pSETUP  = C_SETUP_DEF,
  parameter int unsigned pSTROBE = C_STROBE_DEF,
  parameter int unsigned pHOLD   = C_HOLD_DEF
) (
  input  logic       clk_usb,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [6:0] cmd_offset,
  input  logic [6:0] cmd_len,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       done,
  output logic       err,
  output logic [7:0] usb_data_o,
  output logic       usb_data_oe,
  input  logic [7:0] usb_data_i,
  output logic [7:0] usb_addr,
  output logic [6:0] usb_addr_bytecount,
  output logic       usb_cen,
  output logic       usb_rdn,
  output logic       usb_wrn
);

  localparam logic [3:0] c_setup_ld  = 4'(pSETUP - 1);
  localparam logic [3:0] c_strobe_ld = 4'(pSTROBE - 1);
  localparam logic [3:0] c_hold_ld   = 4'(pHOLD - 1);

  bus_state_t r_state, w_next;
  logic [7:0] r_addr, r_wdata, r_rd_data;
  logic [6:0] r_bc, r_left, w_len;
  logic       r_write, r_err, r_have, r_armed, r_rd_valid;
  logic       w_tmr_load, w_tmr_zero, w_accept, w_wr_take, w_more;
  logic [3:0] w_tmr_val;

`ifdef USB_MASTER_BURST_EN
  assign w_len = cmd_len;
`else
  assign w_len = (cmd_len != 7'd0) ? 7'd1 : 7'd0;
`endif

  assign w_accept  = cmd_valid & cmd_ready;
  assign w_wr_take = wr_valid & wr_ready;
  assign w_more    = (r_left != 7'd1);

  usb_phase_timer u_timer (
    .clk_usb    (clk_usb),
    .reset      (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge clk_usb or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Bus pins decode straight from the state register so an asynchronous
  // reset releases the strobes and chip enable immediately.
  always_comb begin
    w_next      = r_state;
    w_tmr_load  = 1'b0;
    w_tmr_val   = c_setup_ld;
    cmd_ready   = 1'b0;
    wr_ready    = 1'b0;
    usb_cen     = 1'b1;
    usb_rdn     = 1'b1;
    usb_wrn     = 1'b1;
    usb_data_oe = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = r_armed;
        if (cmd_valid && r_armed) begin
          if (w_len == 7'd0) begin
            w_next = ST_ERR;
          end else begin
            w_next     = ST_SETUP;
            w_tmr_load = 1'b1;
            w_tmr_val  = c_setup_ld;
          end
        end
      end
      ST_SETUP: begin
        usb_cen     = 1'b0;
        usb_data_oe = r_write;
        // Offered until the byte is taken; with no stall this is one cycle.
        wr_ready    = r_write & ~r_have;
        if (w_tmr_zero && (!r_write || r_have || wr_valid)) begin
          w_next     = ST_STROBE;
          w_tmr_load = 1'b1;
          w_tmr_val  = c_strobe_ld;
        end
      end
      ST_STROBE: begin
        usb_cen     = 1'b0;
        usb_data_oe = r_write;
        usb_rdn     = r_write;
        usb_wrn     = ~r_write;
        if (w_tmr_zero) begin
          w_next     = ST_HOLD;
          w_tmr_load = 1'b1;
          w_tmr_val  = c_hold_ld;
        end
      end
      ST_HOLD: begin
        usb_cen     = 1'b0;
        usb_data_oe = r_write;
        if (w_tmr_zero) begin
          if (w_more) begin
            w_next     = ST_SETUP;
            w_tmr_load = 1'b1;
            w_tmr_val  = c_setup_ld;
          end else begin
            w_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done   = 1'b1;
        err    = r_err;
        w_next = ST_IDLE;
      end
      ST_ERR:  w_next = ST_DONE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_usb or posedge reset) begin
    if (reset) begin
      r_addr     <= 8'd0;
      r_bc       <= 7'd0;
      r_left     <= 7'd0;
      r_write    <= 1'b0;
      r_err      <= 1'b0;
      r_wdata    <= 8'd0;
      r_have     <= 1'b0;
      r_armed    <= 1'b0;
      r_rd_data  <= 8'd0;
      r_rd_valid <= 1'b0;
    end else begin
      // Holds cmd_ready low for the first clock out of reset.
      r_armed    <= 1'b1;
      r_rd_valid <= 1'b0;
      if (w_accept) begin
        r_addr  <= cmd_addr;
        r_bc    <= cmd_offset;
        r_left  <= w_len;
        r_write <= cmd_write;
        r_err   <= (w_len == 7'd0);
      end
      if (w_wr_take) begin
        r_wdata <= wr_data;
        r_have  <= 1'b1;
      end
      if (r_state == ST_STROBE && w_tmr_zero && !r_write) begin
        r_rd_data  <= usb_data_i;
        r_rd_valid <= 1'b1;
      end
      if (r_state == ST_HOLD && w_tmr_zero) begin
        r_have <= 1'b0;
        if (w_more) begin
          r_bc   <= r_bc + 7'd1;   // 7-bit wrap 127 -> 0
          r_left <= r_left - 7'd1;
        end
      end
    end
  end

  assign usb_addr           = r_addr;
  assign usb_addr_bytecount = r_bc;
  assign usb_data_o         = r_wdata;
  assign rd_data            = r_rd_data;
  assign rd_valid           = r_rd_valid;

endmodule : usb_reg_master
`default_nettype wire
